// File: rtl/addr_dual_queue.sv
// Two-lane in-order FIFO of (rs, rt) register-address pairs.
// Sits between decode and register-file read on the dual-issue path.
module addr_dual_queue #(
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 16,
  parameter int CWIDTH = 5
) (
  input  logic              aq_clk,
  input  logic              aq_rst,
  input  logic              aq_i_flush,
  input  logic [1:0]        aq_i_we,
  input  logic [AWIDTH-1:0] aq_i_addr_rs0,
  input  logic [AWIDTH-1:0] aq_i_addr_rt0,
  input  logic [AWIDTH-1:0] aq_i_addr_rs1,
  input  logic [AWIDTH-1:0] aq_i_addr_rt1,
  input  logic [1:0]        aq_i_re,
  output logic [AWIDTH-1:0] aq_o_addr_rs0,
  output logic [AWIDTH-1:0] aq_o_addr_rt0,
  output logic [AWIDTH-1:0] aq_o_addr_rs1,
  output logic [AWIDTH-1:0] aq_o_addr_rt1,
  output logic [1:0]        aq_o_valid,
  output logic [CWIDTH-1:0] aq_o_count,
  output logic              aq_o_empty,
  output logic              aq_o_full,
  output logic              aq_o_afull,
  output logic              aq_o_wdrop
);

  localparam int PW = CWIDTH - 1;

  typedef struct packed {
    logic [AWIDTH-1:0] rs;
    logic [AWIDTH-1:0] rt;
  } pair_t;

  pair_t mem [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr1;
  logic [PW-1:0]     rd_ptr1;
  logic [CWIDTH-1:0] count;
  logic [CWIDTH-1:0] free;
  logic [1:0]        nw;
  logic [1:0]        nr;
  logic              wr_ok;
  logic              drop;
  logic              g0;
  logic              g1;
  pair_t             lane0;
  pair_t             lane1;

  assign wr_ptr1 = wr_ptr + PW'(1);
  assign rd_ptr1 = rd_ptr + PW'(1);
  assign free    = CWIDTH'(DEPTH) - count;
  assign nw      = {1'b0, aq_i_we[0]} + {1'b0, aq_i_we[1]};
  assign lane0   = '{rs: aq_i_addr_rs0, rt: aq_i_addr_rt0};
  assign lane1   = '{rs: aq_i_addr_rs1, rt: aq_i_addr_rt1};

  // Writes are all-or-nothing against start-of-cycle occupancy
  always_comb begin
    wr_ok = 1'b0;
    drop  = 1'b0;
    if (!aq_i_flush && nw != 2'd0) begin
      if (CWIDTH'(nw) <= free) wr_ok = 1'b1;
      else                     drop  = 1'b1;
    end
  end

  assign g0 = !aq_i_flush && aq_i_re[0] && count >= CWIDTH'(1);
  assign g1 = !aq_i_flush && &aq_i_re && count >= CWIDTH'(2);
  assign nr = {1'b0, g0} + {1'b0, g1};

  always_ff @(posedge aq_clk) begin
    if (wr_ok) begin
      unique case (aq_i_we)
        2'b11: begin
          mem[wr_ptr]  <= lane0;
          mem[wr_ptr1] <= lane1;
        end
        2'b01:   mem[wr_ptr] <= lane0;
        2'b10:   mem[wr_ptr] <= lane1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge aq_clk or posedge aq_rst) begin
    if (aq_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (aq_i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(nw);
      rd_ptr <= rd_ptr + PW'(nr);
      count  <= count + (wr_ok ? CWIDTH'(nw) : '0) - CWIDTH'(nr);
    end
  end

  always_ff @(posedge aq_clk or posedge aq_rst) begin
    if (aq_rst) begin
      aq_o_valid    <= 2'b00;
      aq_o_wdrop    <= 1'b0;
      aq_o_addr_rs0 <= '0;
      aq_o_addr_rt0 <= '0;
      aq_o_addr_rs1 <= '0;
      aq_o_addr_rt1 <= '0;
    end else if (aq_i_flush) begin
      aq_o_valid    <= 2'b00;
      aq_o_wdrop    <= 1'b0;
      aq_o_addr_rs0 <= '0;
      aq_o_addr_rt0 <= '0;
      aq_o_addr_rs1 <= '0;
      aq_o_addr_rt1 <= '0;
    end else begin
      aq_o_valid <= {g1, g0};
      aq_o_wdrop <= drop;
      if (g0) begin
        aq_o_addr_rs0 <= mem[rd_ptr].rs;
        aq_o_addr_rt0 <= mem[rd_ptr].rt;
      end
      if (g1) begin
        aq_o_addr_rs1 <= mem[rd_ptr1].rs;
        aq_o_addr_rt1 <= mem[rd_ptr1].rt;
      end
    end
  end

  assign aq_o_count = count;
  assign aq_o_empty = count == '0;
  assign aq_o_full  = count == CWIDTH'(DEPTH);
  assign aq_o_afull = count >= CWIDTH'(DEPTH - 1);

endmodule

// File: tb/tb_addr_dual_queue.sv
// Directed bench for addr_dual_queue.
// Expected values are hand-derived from the queue's ordering rules.
module tb_addr_dual_queue;

  logic       aq_clk = 1'b0;
  logic       aq_rst;
  logic       aq_i_flush;
  logic [1:0] aq_i_we;
  logic [4:0] aq_i_addr_rs0;
  logic [4:0] aq_i_addr_rt0;
  logic [4:0] aq_i_addr_rs1;
  logic [4:0] aq_i_addr_rt1;
  logic [1:0] aq_i_re;
  logic [4:0] aq_o_addr_rs0;
  logic [4:0] aq_o_addr_rt0;
  logic [4:0] aq_o_addr_rs1;
  logic [4:0] aq_o_addr_rt1;
  logic [1:0] aq_o_valid;
  logic [4:0] aq_o_count;
  logic       aq_o_empty;
  logic       aq_o_full;
  logic       aq_o_afull;
  logic       aq_o_wdrop;

  int n_chk = 0;
  int n_err = 0;

  addr_dual_queue dut (
    .aq_clk        (aq_clk),
    .aq_rst        (aq_rst),
    .aq_i_flush    (aq_i_flush),
    .aq_i_we       (aq_i_we),
    .aq_i_addr_rs0 (aq_i_addr_rs0),
    .aq_i_addr_rt0 (aq_i_addr_rt0),
    .aq_i_addr_rs1 (aq_i_addr_rs1),
    .aq_i_addr_rt1 (aq_i_addr_rt1),
    .aq_i_re       (aq_i_re),
    .aq_o_addr_rs0 (aq_o_addr_rs0),
    .aq_o_addr_rt0 (aq_o_addr_rt0),
    .aq_o_addr_rs1 (aq_o_addr_rs1),
    .aq_o_addr_rt1 (aq_o_addr_rt1),
    .aq_o_valid    (aq_o_valid),
    .aq_o_count    (aq_o_count),
    .aq_o_empty    (aq_o_empty),
    .aq_o_full     (aq_o_full),
    .aq_o_afull    (aq_o_afull),
    .aq_o_wdrop    (aq_o_wdrop)
  );

  always #5 aq_clk = ~aq_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pr(input int rs, input int rt);
    return 32'(((rs & 31) << 5) | (rt & 31));
  endfunction

  task automatic tick();
    @(posedge aq_clk);
    #1;
  endtask

  task automatic idle();
    aq_i_we = 2'b00;
    aq_i_re = 2'b00;
    aq_i_flush = 1'b0;
  endtask

  task automatic wr2(input int a, input int b, input int c,
                     input int d);
    aq_i_we = 2'b11;
    aq_i_addr_rs0 = 5'(a);
    aq_i_addr_rt0 = 5'(b);
    aq_i_addr_rs1 = 5'(c);
    aq_i_addr_rt1 = 5'(d);
    tick();
    aq_i_we = 2'b00;
  endtask

  task automatic wr1(input int a, input int b);
    aq_i_we = 2'b01;
    aq_i_addr_rs0 = 5'(a);
    aq_i_addr_rt0 = 5'(b);
    tick();
    aq_i_we = 2'b00;
  endtask

  wire [31:0] o0 = pr(int'(aq_o_addr_rs0), int'(aq_o_addr_rt0));
  wire [31:0] o1 = pr(int'(aq_o_addr_rs1), int'(aq_o_addr_rt1));

  initial begin
    idle();
    aq_i_addr_rs0 = '0;
    aq_i_addr_rt0 = '0;
    aq_i_addr_rs1 = '0;
    aq_i_addr_rt1 = '0;
    aq_rst = 1'b1;
    tick();
    tick();
    aq_rst = 1'b0;
    tick();
    chk("rst_count", 32'(aq_o_count), 0);
    chk("rst_empty", 32'(aq_o_empty), 1);
    chk("rst_full", 32'(aq_o_full), 0);
    chk("rst_valid", 32'(aq_o_valid), 0);
    chk("rst_addr0", o0, 0);
    chk("rst_addr1", o1, 0);

    for (int i = 0; i < 16; i += 2) wr2(i, i, i + 1, i + 1);
    chk("fill_count", 32'(aq_o_count), 16);
    chk("fill_full", 32'(aq_o_full), 1);
    chk("fill_afull", 32'(aq_o_afull), 1);
    for (int k = 0; k < 8; k++) begin
      aq_i_re = 2'b11;
      tick();
      chk("drain_valid", 32'(aq_o_valid), 2'b11);
      chk("drain_lane0", o0, pr(2 * k, 2 * k));
      chk("drain_lane1", o1, pr(2 * k + 1, 2 * k + 1));
    end
    idle();
    tick();
    chk("drain_idle_valid", 32'(aq_o_valid), 0);
    chk("drain_empty", 32'(aq_o_empty), 1);

    for (int i = 0; i < 7; i++) wr2(i, 1, i, 2);
    wr1(20, 20);
    chk("pre_rej_count", 32'(aq_o_count), 15);
    chk("pre_rej_afull", 32'(aq_o_afull), 1);
    chk("pre_rej_full", 32'(aq_o_full), 0);
    wr2(1, 1, 1, 1);
    chk("rej_count", 32'(aq_o_count), 15);
    chk("rej_wdrop", 32'(aq_o_wdrop), 1);
    tick();
    chk("rej_wdrop_clr", 32'(aq_o_wdrop), 0);
    wr1(21, 21);
    chk("after_rej_count", 32'(aq_o_count), 16);
    chk("after_rej_full", 32'(aq_o_full), 1);
    chk("after_rej_wdrop", 32'(aq_o_wdrop), 0);
    aq_i_re = 2'b11;
    for (int k = 0; k < 8; k++) tick();
    idle();
    chk("rej_drain_lane1", o1, pr(21, 21));
    chk("rej_drain_empty", 32'(aq_o_empty), 1);

    wr1(5, 6);
    aq_i_re = 2'b11;
    tick();
    idle();
    chk("part_valid", 32'(aq_o_valid), 2'b01);
    chk("part_lane0", o0, pr(5, 6));
    chk("part_lane1_hold", o1, pr(21, 21));
    chk("part_count", 32'(aq_o_count), 0);
    chk("part_empty", 32'(aq_o_empty), 1);
    aq_i_re = 2'b01;
    tick();
    idle();
    chk("empty_rd_valid", 32'(aq_o_valid), 0);
    chk("empty_rd_lane0_hold", o0, pr(5, 6));

    wr2(1, 2, 3, 4);
    aq_i_we = 2'b10;
    aq_i_addr_rs0 = 5'd31;
    aq_i_addr_rt0 = 5'd31;
    aq_i_addr_rs1 = 5'd9;
    aq_i_addr_rt1 = 5'd8;
    tick();
    idle();
    chk("odd_count", 32'(aq_o_count), 3);
    aq_i_re = 2'b10;
    tick();
    idle();
    chk("re10_valid", 32'(aq_o_valid), 0);
    chk("re10_count", 32'(aq_o_count), 3);
    aq_i_re = 2'b11;
    tick();
    chk("pair_valid", 32'(aq_o_valid), 2'b11);
    chk("pair_lane0", o0, pr(1, 2));
    chk("pair_lane1", o1, pr(3, 4));
    aq_i_re = 2'b01;
    tick();
    idle();
    chk("we10_lane0", o0, pr(9, 8));
    chk("we10_valid", 32'(aq_o_valid), 2'b01);
    chk("we10_count", 32'(aq_o_count), 0);

    wr2(30, 1, 31, 2);
    for (int v = 0; v < 40; v++) begin
      aq_i_we = 2'b01;
      aq_i_addr_rs0 = 5'(v);
      aq_i_addr_rt0 = 5'(3 * v);
      aq_i_re = 2'b01;
      tick();
      chk("wrap_count", 32'(aq_o_count), 2);
      chk("wrap_valid", 32'(aq_o_valid), 2'b01);
      if (v == 0)      chk("wrap_data", o0, pr(30, 1));
      else if (v == 1) chk("wrap_data", o0, pr(31, 2));
      else             chk("wrap_data", o0, pr(v - 2, 3 * (v - 2)));
    end
    idle();

    for (int i = 0; i < 3; i++) wr2(i, i, i, i);
    wr1(4, 4);
    chk("pre_flush_count", 32'(aq_o_count), 9);
    aq_i_flush = 1'b1;
    aq_i_we = 2'b11;
    aq_i_re = 2'b11;
    tick();
    idle();
    chk("flush_count", 32'(aq_o_count), 0);
    chk("flush_empty", 32'(aq_o_empty), 1);
    chk("flush_valid", 32'(aq_o_valid), 0);
    chk("flush_wdrop", 32'(aq_o_wdrop), 0);
    wr1(7, 3);
    aq_i_re = 2'b01;
    tick();
    idle();
    chk("post_flush_data", o0, pr(7, 3));
    chk("post_flush_valid", 32'(aq_o_valid), 2'b01);
    chk("post_flush_count", 32'(aq_o_count), 0);

    wr2(10, 10, 11, 11);
    #2;
    aq_rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(aq_o_count), 0);
    chk("async_rst_addr0", o0, 0);
    aq_rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
